// File: rtl/pool_pkg.sv
// Shared types and helpers for the ReLU / 2x2 max-pool stage.
package pool_pkg;
  localparam int POOL_DATA_W = 21;
  localparam int POOL_CH     = 3;
  localparam int WORD_W      = POOL_CH * POOL_DATA_W;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EVEN,
    S_ODD
  } state_t;

  // Channel 0 sits in the MSBs of the packed word.
  function automatic logic signed [POOL_DATA_W-1:0] ch_slice(
    input logic [WORD_W-1:0] w,
    input int                i
  );
    return w[(POOL_CH-1-i)*POOL_DATA_W +: POOL_DATA_W];
  endfunction
endpackage

// File: rtl/pool_max2.sv
// Per-channel signed max of two packed words; ties keep a_i.
// With RELU_EN defined, each channel result is clamped at zero.
module pool_max2
  import pool_pkg::*;
(
  input  logic [WORD_W-1:0] a_i,
  input  logic [WORD_W-1:0] b_i,
  output logic [WORD_W-1:0] max_o
);

  function automatic logic signed [POOL_DATA_W-1:0] pick(
    input logic signed [POOL_DATA_W-1:0] ca,
    input logic signed [POOL_DATA_W-1:0] cb
  );
    logic signed [POOL_DATA_W-1:0] m;
    m = (ca >= cb) ? ca : cb;
`ifdef RELU_EN
    if (m < 0) m = '0;
`endif
    return m;
  endfunction

  always_comb begin
    max_o = '0;
    for (int i = 0; i < POOL_CH; i++) begin
      max_o[(POOL_CH-1-i)*POOL_DATA_W +: POOL_DATA_W] =
        pick(ch_slice(a_i, i), ch_slice(b_i, i));
    end
  end

endmodule

// File: rtl/relu_maxpool.sv
// Optional ReLU plus 2x2 stride-2 max pooling over a half-width row buffer.
// Define RELU_EN to clamp negative channels to zero before pooling.
module relu_maxpool
  import pool_pkg::*;
#(
  parameter int DATA_W     = POOL_DATA_W,
  parameter int CH         = POOL_CH,
  parameter int IMG_WIDTH  = 26,
  parameter int IMG_HEIGHT = 26,
  localparam int WW = CH * DATA_W,
  localparam int CW = $clog2(IMG_WIDTH),
  localparam int RW = $clog2(IMG_HEIGHT)
) (
  input  logic          clk,
  input  logic          RESET,
  input  logic          start_rd,
  input  logic          de_in,
  input  logic [WW-1:0] result,
  output logic [WW-1:0] pool_out,
  output logic          pool_valid,
  output logic          frame_done,
  output logic [RW-1:0] row_idx
);

  localparam int NPAIR     = IMG_WIDTH / 2;
  localparam int LAST_PCOL = 2 * NPAIR - 1;
  localparam int LAST_OROW = 2 * (IMG_HEIGHT / 2) - 1;

  state_t        state_q;
  logic [CW-1:0] col_q;
  logic [RW-1:0] row_q;
  logic [WW-1:0] hold_q;
  logic [WW-1:0] pool_out_q;
  logic          pool_valid_q;
  logic          frame_done_q;
  logic [WW-1:0] rowbuf_q [NPAIR];

  logic [WW-1:0] hmax;
  logic [WW-1:0] vmax;
  logic [CW-2:0] bidx;
  state_t        st_eff;
  logic          col_wrap;
  logic          row_last;
  logic          odd_col;
  logic          last_win;

  assign bidx     = col_q[CW-1:1];
  assign odd_col  = col_q[0];
  assign col_wrap = (col_q == CW'(IMG_WIDTH - 1));
  assign row_last = (row_q == RW'(IMG_HEIGHT - 1));
  assign last_win = (col_q == CW'(LAST_PCOL)) &&
                    (row_q == RW'(LAST_OROW));
  // A sample arriving while leaving idle belongs to row 0.
  assign st_eff   = (state_q == S_IDLE) ? S_EVEN : state_q;

  pool_max2 u_hmax (
    .a_i  (hold_q),
    .b_i  (result),
    .max_o(hmax)
  );

  pool_max2 u_vmax (
    .a_i  (rowbuf_q[bidx]),
    .b_i  (hmax),
    .max_o(vmax)
  );

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      state_q      <= S_IDLE;
      col_q        <= '0;
      row_q        <= '0;
      hold_q       <= '0;
      pool_out_q   <= '0;
      pool_valid_q <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      pool_valid_q <= 1'b0;
      frame_done_q <= 1'b0;
      if (!start_rd) begin
        state_q <= S_IDLE;
        col_q   <= '0;
        row_q   <= '0;
        hold_q  <= '0;
      end else begin
        if (state_q == S_IDLE) state_q <= S_EVEN;
        if (de_in) begin
          if (!odd_col) begin
            hold_q <= result;
          end else if (st_eff == S_ODD) begin
            pool_out_q   <= vmax;
            pool_valid_q <= 1'b1;
            frame_done_q <= last_win;
          end
          if (col_wrap) begin
            col_q   <= '0;
            row_q   <= row_last ? '0 : row_q + RW'(1);
            // Odd height: the trailing even row restarts in S_EVEN.
            state_q <= (st_eff == S_EVEN && !row_last) ? S_ODD : S_EVEN;
          end else begin
            col_q <= col_q + CW'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (start_rd && de_in && odd_col && st_eff == S_EVEN)
      rowbuf_q[bidx] <= hmax;
  end

  assign pool_out   = pool_out_q;
  assign pool_valid = pool_valid_q;
  assign frame_done = frame_done_q;
  assign row_idx    = row_q;

endmodule

// File: tb/tb_relu_maxpool.sv
// Directed bench for relu_maxpool: 4x4 and 5x5 instances share inputs.
// Expected values follow RELU_EN when the bench is built with it.
module tb_relu_maxpool;

  logic        clk;
  logic        rst;
  logic        start_rd;
  logic        de_in;
  logic [62:0] result;

  logic [62:0] pa_out, pb_out;
  logic        pa_v, pb_v;
  logic        pa_fd, pb_fd;
  logic [1:0]  pa_row;
  logic [2:0]  pb_row;

  int n_chk  = 0;
  int n_fail = 0;
  logic [62:0] last_exp [2];
  int pulses;

  relu_maxpool #(.IMG_WIDTH(4), .IMG_HEIGHT(4)) dut_a (
    .clk(clk), .RESET(rst), .start_rd(start_rd), .de_in(de_in),
    .result(result), .pool_out(pa_out), .pool_valid(pa_v),
    .frame_done(pa_fd), .row_idx(pa_row)
  );

  relu_maxpool #(.IMG_WIDTH(5), .IMG_HEIGHT(5)) dut_b (
    .clk(clk), .RESET(rst), .start_rd(start_rd), .de_in(de_in),
    .result(result), .pool_out(pb_out), .pool_valid(pb_v),
    .frame_done(pb_fd), .row_idx(pb_row)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [62:0] pix(input int kind, input int r,
                                      input int c, input int w, input int h);
    int v;
    logic signed [20:0] a, b, d;
    if (c >= 2 * (w / 2) || r >= 2 * (h / 2)) v = 999;
    else v = r * w + c;
    case (kind)
      0: begin a = 21'(v); b = 21'(v);  d = 21'(v); end
      1: begin a = 21'(v); b = 21'(-v); d = 21'(100 - v); end
      default: begin a = -21'sd3; b = -21'sd3; d = -21'sd3; end
    endcase
    return {a, b, d};
  endfunction

  function automatic logic [62:0] ewin(input int kind, input int wr,
                                       input int wc, input int w, input int h);
    logic [62:0] res;
    logic [62:0] s;
    logic signed [20:0] m, x;
    res = '0;
    for (int ch = 0; ch < 3; ch++) begin
      s = pix(kind, 2 * wr, 2 * wc, w, h);
      m = s[(2 - ch) * 21 +: 21];
      for (int k = 1; k < 4; k++) begin
        s = pix(kind, 2 * wr + k / 2, 2 * wc + k % 2, w, h);
        x = s[(2 - ch) * 21 +: 21];
        if (x > m) m = x;
      end
`ifdef RELU_EN
      if (m < 0) m = '0;
`endif
      res[(2 - ch) * 21 +: 21] = m;
    end
    return res;
  endfunction

  task automatic step(input int sel, input logic de, input logic [62:0] w,
                      input logic ev, input logic efd, input int erow);
    de_in  = de;
    result = w;
    @(posedge clk);
    #1;
    chk("pool_valid", sel ? 64'(pb_v) : 64'(pa_v), 64'(ev));
    chk("frame_done", sel ? 64'(pb_fd) : 64'(pa_fd), 64'(efd));
    chk("pool_out", sel ? 64'(pb_out) : 64'(pa_out), 64'(last_exp[sel]));
    chk("row_idx", sel ? 64'(pb_row) : 64'(pa_row), 64'(erow));
  endtask

  task automatic run_frame(input int sel, input int kind, input bit gaps,
                           input int nmax, output int npulse);
    int w, h, cnt, er;
    logic ev, efd;
    w = sel ? 5 : 4;
    h = w;
    cnt = 0;
    npulse = 0;
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        if (cnt == nmax) return;
        cnt++;
        if (gaps && (c % 2 == 1)) step(sel, 1'b0, '1, 1'b0, 1'b0, r);
        ev  = (r % 2 == 1) && (c % 2 == 1) &&
              (r < 2 * (h / 2)) && (c < 2 * (w / 2));
        efd = ev && (r == 2 * (h / 2) - 1) && (c == 2 * (w / 2) - 1);
        if (ev) last_exp[sel] = ewin(kind, r / 2, c / 2, w, h);
        er  = (c == w - 1) ? ((r == h - 1) ? 0 : r + 1) : r;
        step(sel, 1'b1, pix(kind, r, c, w, h), ev, efd, er);
        if (ev) npulse++;
      end
    end
    de_in = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_out_a", 64'(pa_out), 64'd0);
    chk("rst_out_b", 64'(pb_out), 64'd0);
    @(negedge clk);
    rst   = 1'b0;
    de_in = 1'b0;
    last_exp[0] = '0;
    last_exp[1] = '0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst      = 1'b1;
    start_rd = 1'b0;
    de_in    = 1'b0;
    result   = '0;
    last_exp[0] = '0;
    last_exp[1] = '0;
    #12;
    chk("reset_out", 64'(pa_out), 64'd0);
    chk("reset_valid", 64'(pa_v), 64'd0);
    chk("reset_fd", 64'(pa_fd), 64'd0);
    chk("reset_row", 64'(pa_row), 64'd0);
    chk("reset_row_b", 64'(pb_row), 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    start_rd = 1'b1;

    // 4x4 ramp: windows 5, 7, 13, 15
    run_frame(0, 0, 1'b0, 100, pulses);
    chk("ramp_pulses", 64'(pulses), 64'd4);
    chk("ramp_last", 64'(pa_out), 64'({3{21'd15}}));

    // mixed-sign channels, back-to-back frame
    run_frame(0, 1, 1'b0, 100, pulses);
    chk("mixed_pulses", 64'(pulses), 64'd4);

    // de_in gaps inside rows
    run_frame(0, 0, 1'b1, 100, pulses);
    chk("gap_pulses", 64'(pulses), 64'd4);
    chk("gap_last", 64'(pa_out), 64'({3{21'd15}}));

    // all -3
    run_frame(0, 2, 1'b0, 100, pulses);
    chk("neg_pulses", 64'(pulses), 64'd4);
`ifdef RELU_EN
    chk("neg_value", 64'(pa_out), 64'd0);
`else
    chk("neg_value", 64'(pa_out), 64'({3{-21'sd3}}));
`endif

    // abort at row 1, col 2
    run_frame(0, 1, 1'b0, 6, pulses);
    chk("abort_pre", 64'(pulses), 64'd1);
    start_rd = 1'b0;
    step(0, 1'b1, pix(1, 1, 2, 4, 4), 1'b0, 1'b0, 0);
    start_rd = 1'b1;
    run_frame(0, 1, 1'b0, 100, pulses);
    chk("abort_post", 64'(pulses), 64'd4);

    // asynchronous reset mid-row
    run_frame(0, 0, 1'b0, 6, pulses);
    chk("mid_valid", 64'(pa_v), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_out", 64'(pa_out), 64'd0);
    chk("async_valid", 64'(pa_v), 64'd0);
    chk("async_fd", 64'(pa_fd), 64'd0);
    chk("async_row", 64'(pa_row), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    de_in = 1'b0;
    last_exp[0] = '0;
    @(posedge clk);
    #1;
    run_frame(0, 0, 1'b0, 100, pulses);
    chk("post_rst_pulses", 64'(pulses), 64'd4);

    // 5x5: column 4 and row 4 are dropped
    do_reset();
    run_frame(1, 1, 1'b0, 100, pulses);
    chk("odd_pulses_1", 64'(pulses), 64'd4);
    run_frame(1, 0, 1'b0, 100, pulses);
    chk("odd_pulses_2", 64'(pulses), 64'd4);
    chk("odd_last", 64'(pb_out), 64'({3{21'd18}}));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
